// File: rtl/rf_wr_arbiter_pkg.sv
// rf_wr_arbiter_pkg: shared types for the register-file write-port arbiter
package rf_wr_arbiter_pkg;
  localparam int RF_XLEN = 32;
  typedef enum logic [1:0] {STALL_NONE, ARB_STALL} stall_e;
  typedef enum logic [1:0] {IDLE, PEND, FORCE} rf_wr_arb_state_e;
  typedef struct packed {
    logic               we;
    logic [4:0]         rd;
    logic [RF_XLEN-1:0] data;
  } rf_wr_req_t;
endpackage

// File: rtl/rf_wr_arbiter_if.sv
// rf_wr_arbiter_if: writeback, late-result and register-file write signals of the arbiter
interface rf_wr_arbiter_if import rf_wr_arbiter_pkg::*; #(parameter int XLEN = RF_XLEN);
  logic            pipe_we_i;
  logic [4:0]      pipe_rd_i;
  logic [XLEN-1:0] pipe_data_i;
  logic            pipe_accept_o;
  logic            late_valid_i;
  logic            late_ready_o;
  logic [4:0]      late_rd_i;
  logic [XLEN-1:0] late_data_i;
  logic            stall_req_o;
  logic            rf_we_o;
  logic [4:0]      rf_waddr_o;
  logic [XLEN-1:0] rf_wdata_o;
  modport slave (
    input  pipe_we_i, pipe_rd_i, pipe_data_i, late_valid_i, late_rd_i, late_data_i,
    output pipe_accept_o, late_ready_o, stall_req_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
  modport master (
    output pipe_we_i, pipe_rd_i, pipe_data_i, late_valid_i, late_rd_i, late_data_i,
    input  pipe_accept_o, late_ready_o, stall_req_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: RF write port arbiter, P priority, 1-entry L buffer, forced drain on starvation; RF_WR_ARB_PERF_EN adds perf counters
module rf_wr_arbiter import rf_wr_arbiter_pkg::*; #(
  parameter int XLEN         = RF_XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  rf_wr_arbiter_if.slave bus
`ifdef RF_WR_ARB_PERF_EN
  ,
  output logic [31:0]    perf_late_wr_o,
  output logic [31:0]    perf_force_o,
  output logic [31:0]    perf_squash_o
`endif
);
  rf_wr_arb_state_e state_q, state_d;
  rf_wr_req_t       buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             grant_l;
  logic             squash;
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = 4'd0;
    grant_l = 1'b0;
    squash  = 1'b0;
    case (state_q)
      IDLE: if (bus.late_valid_i && bus.late_rd_i != 5'd0) begin
        state_d = PEND;
        buf_d   = '{we: 1'b1, rd: bus.late_rd_i, data: bus.late_data_i};
      end
      PEND: begin
        grant_l = !bus.pipe_we_i;
        squash  = bus.pipe_we_i && bus.pipe_rd_i == buf_q.rd;
        state_d = (grant_l || squash) ? IDLE : (cnt_q + 4'd1 == 4'(STARVE_LIMIT)) ? FORCE : PEND;
        cnt_d   = state_d == PEND ? cnt_q + 4'd1 : 4'd0;
      end
      FORCE: begin
        grant_l = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (grant_l || squash) buf_d.we = 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.late_ready_o  = !rst_i && !buf_q.we;
  assign bus.pipe_accept_o = !rst_i && state_q != FORCE;
  assign bus.stall_req_o   = !rst_i && state_q == FORCE;
  assign bus.rf_we_o       = !rst_i && (grant_l || (bus.pipe_we_i && state_q != FORCE));
  assign bus.rf_waddr_o    = grant_l ? buf_q.rd : bus.pipe_rd_i;
  assign bus.rf_wdata_o    = grant_l ? XLEN'(buf_q.data) : bus.pipe_data_i;
`ifdef RF_WR_ARB_PERF_EN
  logic [31:0] perf_late_wr_q, perf_late_wr_d, perf_force_q, perf_force_d, perf_squash_q, perf_squash_d;
  always_comb begin
    perf_late_wr_d = perf_late_wr_q + 32'(grant_l);
    perf_force_d   = perf_force_q + 32'(state_d == FORCE);
    perf_squash_d  = perf_squash_q + 32'(squash);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_late_wr_q <= '0;
      perf_force_q   <= '0;
      perf_squash_q  <= '0;
    end else begin
      perf_late_wr_q <= perf_late_wr_d;
      perf_force_q   <= perf_force_d;
      perf_squash_q  <= perf_squash_d;
    end
  end
  assign perf_late_wr_o = perf_late_wr_q;
  assign perf_force_o   = perf_force_q;
  assign perf_squash_o  = perf_squash_q;
`endif
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed stimulus with a write scoreboard for rf_wr_arbiter
module tb_rf_wr_arbiter;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int bad = 0;
  logic [36:0] exp_q[$];
  rf_wr_arbiter_if #(.XLEN(32)) bus();
`ifdef RF_WR_ARB_PERF_EN
  logic [31:0] perf_late_wr, perf_force, perf_squash;
`endif
  rf_wr_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
`ifdef RF_WR_ARB_PERF_EN
    ,
    .perf_late_wr_o(perf_late_wr),
    .perf_force_o(perf_force),
    .perf_squash_o(perf_squash)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_p(input logic we, input logic [4:0] rd, input logic [31:0] d);
    bus.pipe_we_i = we;
    bus.pipe_rd_i = rd;
    bus.pipe_data_i = d;
  endtask
  task automatic set_l(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.late_valid_i = v;
    bus.late_rd_i = rd;
    bus.late_data_i = d;
  endtask
  always @(negedge clk) begin
    if (bus.rf_we_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%0h:%0h want=none", bus.rf_waddr_o, bus.rf_wdata_o);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({bus.rf_waddr_o, bus.rf_wdata_o} !== e) begin
          bad++;
          $display("FAIL rf_write got=%0h:%0h want=%0h:%0h", bus.rf_waddr_o, bus.rf_wdata_o, e[36:32], e[31:0]);
        end
      end
    end
  end
  initial begin
    rst = 1'b1;
    set_p(1'b1, 5'd2, 32'h22);
    set_l(1'b1, 5'd4, 32'h44);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_rf_we", bus.rf_we_o, 0);
      chk("rst_accept", bus.pipe_accept_o, 0);
      chk("rst_ready", bus.late_ready_o, 0);
      chk("rst_stall", bus.stall_req_o, 0);
      tick();
    end
    rst = 1'b0;
    set_p(1'b0, 5'd0, 32'h0);
    set_l(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("post_rst_ready", bus.late_ready_o, 1);
    chk("post_rst_we", bus.rf_we_o, 0);
    tick();
    set_l(1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("idle_ready", bus.late_ready_o, 1);
    chk("idle_no_we", bus.rf_we_o, 0);
    exp_q.push_back({5'd5, 32'hDEAD_BEEF});
    tick();
    set_l(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("idle_busy", bus.late_ready_o, 0);
    chk("idle_l_we", bus.rf_we_o, 1);
    tick();
    @(negedge clk);
    chk("idle_free", bus.late_ready_o, 1);
    chk("idle_done_we", bus.rf_we_o, 0);
    tick();
    set_l(1'b1, 5'd7, 32'h77);
    @(negedge clk);
    tick();
    set_l(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      set_p(1'b1, 5'd3, 32'h300 + i);
      exp_q.push_back({5'd3, 32'h300 + i});
      @(negedge clk);
      chk("starve_accept", bus.pipe_accept_o, 1);
      chk("starve_stall", bus.stall_req_o, 0);
      tick();
    end
    set_p(1'b1, 5'd3, 32'h304);
    exp_q.push_back({5'd7, 32'h77});
    @(negedge clk);
    chk("force_stall", bus.stall_req_o, 1);
    chk("force_accept", bus.pipe_accept_o, 0);
    chk("force_waddr", bus.rf_waddr_o, 7);
    tick();
    set_p(1'b1, 5'd3, 32'h305);
    exp_q.push_back({5'd3, 32'h305});
    @(negedge clk);
    chk("after_force_stall", bus.stall_req_o, 0);
    chk("after_force_accept", bus.pipe_accept_o, 1);
    chk("after_force_waddr", bus.rf_waddr_o, 3);
    tick();
    set_p(1'b0, 5'd0, 32'h0);
    set_l(1'b1, 5'd9, 32'h99);
    @(negedge clk);
    tick();
    set_l(1'b0, 5'd0, 32'h0);
    set_p(1'b1, 5'd9, 32'h11);
    exp_q.push_back({5'd9, 32'h11});
    @(negedge clk);
    chk("waw_ready_low", bus.late_ready_o, 0);
    chk("waw_accept", bus.pipe_accept_o, 1);
    tick();
    set_p(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("waw_ready_back", bus.late_ready_o, 1);
    chk("waw_no_stale", bus.rf_we_o, 0);
`ifdef RF_WR_ARB_PERF_EN
    chk("perf_squash_waw", perf_squash, 1);
`endif
    tick();
    set_l(1'b1, 5'd0, 32'hBAD);
    @(negedge clk);
    chk("rd0_ready", bus.late_ready_o, 1);
    tick();
    set_l(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("rd0_ready_stays", bus.late_ready_o, 1);
    chk("rd0_no_write", bus.rf_we_o, 0);
    tick();
    for (int k = 0; k < 3; k++) exp_q.push_back({5'(k + 1), 32'hA1 + k});
    for (int c = 0; c < 6; c++) begin
      set_l(1'b1, 5'(c / 2 + 1), 32'hA1 + c / 2);
      @(negedge clk);
      chk("b2b_ready", bus.late_ready_o, (c % 2 == 0) ? 1 : 0);
      chk("b2b_we", bus.rf_we_o, (c % 2 == 1) ? 1 : 0);
      tick();
    end
    set_l(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("b2b_idle_ready", bus.late_ready_o, 1);
    tick();
`ifdef RF_WR_ARB_PERF_EN
    chk("perf_late_wr", perf_late_wr, 5);
    chk("perf_force", perf_force, 1);
    chk("perf_squash", perf_squash, 1);
`endif
    set_l(1'b1, 5'd12, 32'hCC);
    @(negedge clk);
    tick();
    set_l(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("midpend_rst_we", bus.rf_we_o, 0);
    chk("midpend_rst_ready", bus.late_ready_o, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midpend_ready", bus.late_ready_o, 1);
    chk("midpend_no_write", bus.rf_we_o, 0);
    tick();
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Arbitrates the single integer register-file write port between two requesters:
  - the in-order writeback stage (port P);
  - the late-result path from multi-cycle units such as the iterative divider and long CSR ops (port L).
- Port P has priority.
- Port L results wait in a 1-entry buffer and take idle write-port slots.
- If L starves, the arbiter forces a one-cycle pipeline hold and drains L.

Parameters:
- XLEN, 32, datapath width.
- STARVE_LIMIT, 4, number of consecutive ungranted cycles of a valid L entry before a forced drain (range 1..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- pipe_we_i  in  1  writeback stage requests a write (already qualified for stalls and flushes)
- pipe_rd_i  in  5  writeback destination register
- pipe_data_i  in  XLEN  writeback data
- pipe_accept_o  out  1  P write committed this cycle; when low, the stage must hold its instruction
- late_valid_i  in  1  L result valid
- late_ready_o  out  1  arbiter can accept an L result
- late_rd_i  in  5  L destination register
- late_data_i  in  XLEN  L result data
- stall_req_o  out  1  hold request to the hazard unit, mapped to a new stall_e entry ARB_STALL
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  XLEN  register-file write data

Behaviour:
- Reset (rst_i high at a clock edge):
  - buf_valid=0, state=IDLE, starve_cnt=0.
  - While rst_i is high, all outputs are forced to 0: rf_we_o, pipe_accept_o, late_ready_o, stall_req_o.
- Buffer:
  - late_ready_o = !buf_valid.
  - Capture {late_rd_i, late_data_i} when late_valid_i && late_ready_o.
  - Throughput is one L result every 2 cycles minimum.
  - A captured entry with rd=0 is dropped at capture and buf_valid stays 0.
- States:
  - IDLE: buffer empty.
  - PEND: buffer valid.
  - FORCE: forced drain.
- IDLE:
  - rf_* = P, pipe_accept_o=1.
  - Go to PEND on capture.
- PEND:
  - If pipe_we_i=0: grant L (rf_* = buffer, rf_we_o=1), clear the buffer, go to IDLE.
  - If pipe_we_i=1: grant P, starve_cnt++.
  - If pipe_we_i=1 and pipe_rd_i == buffered rd: WAW squash. The buffer is discarded (the younger P write wins), go to IDLE, starve_cnt=0.
  - On the edge where starve_cnt reaches STARVE_LIMIT, go to FORCE.
- FORCE:
  - stall_req_o=1 (driven from a registered state bit, no combinational path from inputs).
  - pipe_accept_o=0; grant L; clear the buffer; go to IDLE next cycle.
  - FORCE lasts exactly 1 cycle.
- starve_cnt clears on every exit from PEND.
- Outputs are combinational from state, buffer and P inputs. Latency is 0 for P, and L is written at least 1 cycle after capture.
- pipe_accept_o is 1 in IDLE and PEND even when pipe_we_i=0.
- Simultaneous capture and grant cannot occur, because late_ready_o is 0 while the buffer is valid.
- Reset mid-FORCE or mid-PEND discards the buffered result. The L unit is reset by the same rst_i.

Optional Feature:
- RF_WR_ARB_PERF_EN defined adds three 32-bit wrapping counters with read-only output ports:
  - perf_late_wr_o: L writes committed.
  - perf_force_o: FORCE entries.
  - perf_squash_o: WAW squashes.
- The counters are cleared by rst_i.
- Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- ceres_param additions:
  - ARB_STALL in stall_e;
  - rf_wr_arb_state_e {IDLE, PEND, FORCE};
  - struct rf_wr_req_t {we, rd[4:0], data[XLEN-1:0]}, used for the P, L and buffer payloads.
- No sub-module: the FSM, buffer and counter live in one module (about 150 lines).

Test Plan:
- Reset: hold rst_i for 2 cycles with late_valid_i=1 -> all outputs 0, and after release late_ready_o=1 with no stale write.
- Idle slot: L result rd=5, data=0xDEAD_BEEF, with pipe_we_i=0 on the following cycles -> write x5=0xDEADBEEF exactly 1 cycle after capture, late_ready_o=0 for 1 cycle.
- Starvation: L rd=7 captured, then pipe_we_i=1 with rd=3 every cycle, STARVE_LIMIT=4:
  - P commits for 4 cycles;
  - the 5th cycle shows stall_req_o=1, pipe_accept_o=0, rf_waddr_o=7;
  - the 6th cycle shows P x3 commits.
- WAW: L rd=9 buffered, then P writes rd=9 data=0x11 -> only 0x11 is written, buffer cleared, late_ready_o=1 next cycle, perf_squash_o=1.
- rd=0: L result rd=0 -> no write, buf_valid stays 0, late_ready_o stays 1.
- Back-to-back L: late_valid_i held high with rd 1,2,3 while P is idle -> writes on alternate cycles, in order, with none lost.
